// File: rtl/tx_uart_arbiter.sv
// rtl/tx_uart_arbiter.sv - shares one tx_uart among N_REQ byte producers; TX_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority
module tx_uart_arbiter #(
  parameter int DBIT       = 8,
  parameter int N_REQ      = 4,
  parameter int NB_IDX     = 2,
  parameter int TIMEOUT    = 1_000_000,
  parameter int NB_TIMEOUT = 20
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*DBIT-1:0] i_data,
  output logic [N_REQ-1:0]      o_grant,
  output logic [N_REQ-1:0]      o_done,
  output logic                  o_timeout,
  output logic                  o_busy,
  output logic                  o_tx_start,
  output logic [DBIT-1:0]       o_tx_data,
  input  logic                  i_tx_done_tick
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [NB_IDX-1:0]       sel_idx;
  logic [N_REQ-1:0]        sel_onehot;
  logic [NB_TIMEOUT-1:0]   cnt;
  logic                    cnt_hit;
  logic                    win_valid;
  logic [NB_IDX-1:0]       win_idx;
  logic [DBIT-1:0]         win_data;

  assign sel_onehot = N_REQ'(1) << sel_idx;
  assign cnt_hit    = (cnt == NB_TIMEOUT'(TIMEOUT - 1));

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic [NB_IDX-1:0] ptr;
  logic [NB_IDX-1:0] cand;

  // Round-robin search starting just after the last served requester
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = NB_IDX'((int'(ptr) + k) % N_REQ);
      if (!win_valid && i_req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer moves to the requester whose transfer just ended (done or timeout)
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ptr <= NB_IDX'(N_REQ - 1);
    end else if (state == WAIT_DONE && (i_tx_done_tick || cnt_hit)) begin
      ptr <= sel_idx;
    end
  end
`else
  // Fixed priority: lowest asserted index wins
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        win_valid = 1'b1;
        win_idx   = NB_IDX'(k);
      end
    end
  end
`endif

  // Byte of the chosen requester
  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_idx == NB_IDX'(k)) win_data = i_data[k*DBIT +: DBIT];
    end
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next = state;
    o_tx_start = 1'b0;
    o_grant    = '0;
    o_busy     = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) state_next = START;
      end
      START: begin
        o_tx_start = 1'b1;
        o_grant    = sel_onehot;
        o_busy     = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        o_busy = 1'b1;
        if (i_tx_done_tick || cnt_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latched byte/winner, timeout counter and registered completion pulses
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_tx_data <= '0;
      sel_idx   <= '0;
      cnt       <= '0;
      o_done    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_done    <= '0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            o_tx_data <= win_data;
            sel_idx   <= win_idx;
          end
        end
        START: begin
          cnt <= '0;
        end
        WAIT_DONE: begin
          cnt <= cnt + NB_TIMEOUT'(1);
          // A done tick on the same cycle as the timeout still counts as success
          if (i_tx_done_tick) o_done    <= sel_onehot;
          else if (cnt_hit)   o_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_uart_arbiter.sv
// tb/tb_tx_uart_arbiter.sv - self-checking bench for tx_uart_arbiter
module tb_tx_uart_arbiter;

  localparam int DBIT    = 8;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 50;

  logic                  clk = 1'b0;
  logic                  i_reset;
  logic [N_REQ-1:0]      i_req;
  logic [N_REQ*DBIT-1:0] i_data;
  logic [N_REQ-1:0]      o_grant;
  logic [N_REQ-1:0]      o_done;
  logic                  o_timeout;
  logic                  o_busy;
  logic                  o_tx_start;
  logic [DBIT-1:0]       o_tx_data;
  logic                  i_tx_done_tick;

  int checks = 0;
  int errors = 0;

  int        exp_idx_q[$];
  logic [7:0] exp_data_q[$];

  tx_uart_arbiter #(
    .DBIT(DBIT), .N_REQ(N_REQ), .NB_IDX(2), .TIMEOUT(TIMEOUT), .NB_TIMEOUT(6)
  ) dut (
    .i_clock(clk),
    .i_reset(i_reset),
    .i_req(i_req),
    .i_data(i_data),
    .o_grant(o_grant),
    .o_done(o_done),
    .o_timeout(o_timeout),
    .o_busy(o_busy),
    .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data),
    .i_tx_done_tick(i_tx_done_tick)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every grant pops the expected winner and byte
  always @(negedge clk) begin
    if (o_grant != '0) begin
      int         ei;
      logic [7:0] ed;
      logic [3:0] eg;
      checks++;
      if (exp_idx_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got grant=%b, required no grant", o_grant);
      end else begin
        ei = exp_idx_q.pop_front();
        ed = exp_data_q.pop_front();
        eg = 4'b0001 << ei;
        if (o_grant !== eg || o_tx_data !== ed || o_tx_start !== 1'b1) begin
          errors++;
          $display("FAIL grant_scoreboard: got grant=%b data=%h start=%b, required grant=%b data=%h start=1",
                   o_grant, o_tx_data, o_tx_start, eg, ed);
        end
      end
    end
  end

  task automatic push_exp(input int idx, input logic [7:0] d);
    exp_idx_q.push_back(idx);
    exp_data_q.push_back(d);
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_grant != '0) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pulse_done(input int gap);
    repeat (gap) @(negedge clk);
    i_tx_done_tick = 1'b1;
    @(negedge clk);
    i_tx_done_tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
  endtask

  task automatic test_reset();
    int lat;
    i_req  = 4'b1111;
    i_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({o_tx_start, o_grant, o_done, o_timeout, o_busy, o_tx_data} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got start=%b grant=%b done=%b to=%b busy=%b data=%h, required all 0",
                 o_tx_start, o_grant, o_done, o_timeout, o_busy, o_tx_data);
      end
    end
    push_exp(0, 8'h11);
    i_reset = 1'b1;
    wait_grant(lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL reset_first_grant_latency: got %0d cycles, required 1", lat);
    end
    i_req = '0;
    pulse_done(1);
    checks++;
    if (o_done !== 4'b0001) begin
      errors++;
      $display("FAIL reset_done: got %b, required 0001", o_done);
    end
  endtask

  task automatic test_single();
    int lat;
    @(negedge clk);
    i_data = {8'h00, 8'hAA, 8'h00, 8'h00};
    i_req  = 4'b0100;
    push_exp(2, 8'hAA);
    wait_grant(lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required 1", lat);
    end
    i_req          = '0;
    i_data         = {8'h00, 8'h55, 8'h00, 8'h00};
    i_tx_done_tick = 1'b1;
    @(negedge clk);
    i_tx_done_tick = 1'b0;
    checks++;
    if (o_done !== 4'b0000 || o_busy !== 1'b1 || o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL single_tick_in_start: got done=%b busy=%b start=%b, required done=0000 busy=1 start=0",
               o_done, o_busy, o_tx_start);
    end
    pulse_done(3);
    checks++;
    if (o_done !== 4'b0100 || o_tx_data !== 8'hAA) begin
      errors++;
      $display("FAIL single_done: got done=%b data=%h, required done=0100 data=aa", o_done, o_tx_data);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse_width: got done=%b busy=%b, required 0000 and 0", o_done, o_busy);
    end
  endtask

  task automatic test_contention();
    int order[5];
    int lat;
    logic [3:0] eg;
`ifdef TX_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 0, 0, 0, 0};
`endif
    apply_reset();
    i_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int n = 0; n < 5; n++) push_exp(order[n], 8'hA0 + 8'(order[n]) * 8'h11);
    i_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(lat);
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL contention_back_to_back_%0d: got %0d cycles to grant, required 1", n, lat);
      end
      pulse_done(1);
      if (n == 4) i_req = '0;
      eg = 4'b0001 << order[n];
      checks++;
      if (o_done !== eg) begin
        errors++;
        $display("FAIL contention_done_%0d: got %b, required %b", n, o_done, eg);
      end
    end
  endtask

  task automatic test_timeout();
    int lat;
    int hit;
    bit saw_done;
    @(negedge clk);
    i_data = {8'h00, 8'h00, 8'h5C, 8'h00};
    i_req  = 4'b0010;
    push_exp(1, 8'h5C);
    wait_grant(lat);
    i_req    = '0;
    hit      = 0;
    saw_done = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (o_done != '0) saw_done = 1'b1;
      if (o_timeout) begin
        hit = c;
        break;
      end
    end
    checks++;
    if (hit != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles after start, required %0d", hit, TIMEOUT + 1);
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL timeout_no_done: got done pulse, required none");
    end
    @(negedge clk);
    checks++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_return_idle: got timeout=%b busy=%b, required 0 and 0", o_timeout, o_busy);
    end
  endtask

  task automatic test_collision();
    int lat;
    @(negedge clk);
    i_data = {8'h00, 8'h7E, 8'h00, 8'h00};
    i_req  = 4'b0100;
    push_exp(2, 8'h7E);
    wait_grant(lat);
    i_req = '0;
    pulse_done(TIMEOUT);
    checks++;
    if (o_done !== 4'b0100 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL collision: got done=%b timeout=%b, required done=0100 timeout=0", o_done, o_timeout);
    end
    @(negedge clk);
    checks++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL collision_after: got timeout=%b busy=%b, required 0 and 0", o_timeout, o_busy);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    bit saw_done;
    @(negedge clk);
    i_data = {8'h9D, 8'h9C, 8'h9B, 8'h9A};
    i_req  = 4'b0010;
    push_exp(1, 8'h9B);
    wait_grant(lat);
    i_req = '0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_immediate: got busy=%b data=%h, required 0 and 00", o_busy, o_tx_data);
    end
    i_req = 4'b1111;
    push_exp(0, 8'h9A);
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (o_done != '0 || o_timeout) saw_done = 1'b1;
    end
    i_reset = 1'b1;
    wait_grant(lat);
    checks++;
    if (saw_done || lat != 1) begin
      errors++;
      $display("FAIL mid_reset_restart: got stray_pulse=%0d latency=%0d, required 0 and 1", saw_done, lat);
    end
    i_req = '0;
    pulse_done(2);
    checks++;
    if (o_done !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_done: got %b, required 0001", o_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within time limit, required completion");
    $fatal(1);
  end

  initial begin
    i_reset        = 1'b0;
    i_req          = '0;
    i_data         = '0;
    i_tx_done_tick = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_collision();
    test_mid_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_idx_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending grants, required 0", exp_idx_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
